ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive LCD-denied cycles before a forced LCD slot (range 1-15).
REQ-002 SHALL have ports clk  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have CPU ports cpu_req in 1 access valid; cpu_write in 1 write; cpu_addr in 12; cpu_wdata in 4; cpu_stall out 1 CPU must hold its cycle; cpu_rdata out 4.
REQ-004 SHALL have LCD ports lcd_req in 1; lcd_addr in 12; lcd_gnt out 1; lcd_rvalid out 1; lcd_rdata out 4 (read-only).
REQ-005 SHALL have debug ports dbg_req in 1; dbg_write in 1; dbg_addr in 12; dbg_wdata in 4; dbg_gnt out 1; dbg_rvalid out 1; dbg_rdata out 4.
REQ-006 SHALL have RAM ports ram_addr out 12; ram_we out 1; ram_wdata out 4; ram_rdata in 4 (synchronous RAM, read data one cycle after address).

Function
REQ-007 SHALL grant exactly one requester per cycle; ram_addr/ram_we/ram_wdata are combinational from the winner.
REQ-008 SHALL use priority: forced LCD slot > CPU > LCD > debug.
REQ-009 SHALL raise a forced LCD slot when lcd_req=1 and starve_cnt==STARVE_LIMIT; in that cycle cpu_stall=1, lcd_gnt=1, CPU access not performed.
REQ-010 SHALL keep cpu_stall=0 in every other cycle; CPU is never denied except by a forced slot.
REQ-011 SHALL keep 4-bit starve_cnt: +1 on each cycle lcd_req=1 and lcd_gnt=0; clear to 0 on lcd_gnt=1 or lcd_req=0; saturate at STARVE_LIMIT.
REQ-012 SHALL pulse lcd_gnt/dbg_gnt for one cycle, combinationally, in the cycle the access is driven to RAM; requester holds req/addr/data stable until gnt.
REQ-013 SHALL drive ram_we=1 only for a granted write (cpu_write or dbg_write); LCD never writes.
REQ-014 SHALL, on an idle cycle (no grant), drive ram_addr=0, ram_we=0, ram_wdata=0.
REQ-015 SHALL register read owner (CPU/LCD/DBG/NONE) one cycle; next cycle route ram_rdata to that owner's rdata and pulse its rvalid for one cycle.
REQ-016 SHALL hold each rdata output at its last returned value when not being updated.
REQ-017 SHALL assert no rvalid for write grants.
REQ-018 SHALL allow back-to-back grants to different requesters with no idle cycle; read returns pipeline one per cycle.
REQ-019 SHALL treat an LCD request withdrawn before grant as cancelled (counter clears, no rvalid).

Reset
REQ-020 SHALL, while reset_n=0, force ram_we=0, all gnt=0, cpu_stall=0, regardless of requests.
REQ-021 SHALL reset starve_cnt=0, read owner=NONE, all rvalid=0, all rdata=4'h0.
REQ-022 SHALL discard a read in flight when reset asserts mid-operation; no rvalid after release.
REQ-023 SHALL accept grants on the first clk edge after reset_n deasserts.

Configuration
REQ-024 SHALL compile the debug port only when macro RAM_ARBITER_DEBUG_EN is defined.
REQ-025 SHALL, with RAM_ARBITER_DEBUG_EN defined, arbitrate debug per REQ-008.
REQ-026 SHALL, without RAM_ARBITER_DEBUG_EN, keep the ports, ignore dbg_req, and tie dbg_gnt, dbg_rvalid, dbg_rdata to 0.

Verification
REQ-027 SHALL test CPU read: cpu_req=1, cpu_addr=12'h0A3, RAM holds 4'h5 -> ram_addr=0A3 same cycle, cpu_rdata=5 next cycle, cpu_stall=0.
REQ-028 SHALL test starvation: STARVE_LIMIT=8, cpu_req and lcd_req held 1 -> 8 CPU grants, then cycle 9 cpu_stall=1, lcd_gnt=1, counter 0, repeat every 9 cycles.
REQ-029 SHALL test LCD idle grant: cpu_req=0, lcd_req=1 addr 12'hE00 -> lcd_gnt=1 same cycle, lcd_rvalid=1 with RAM data next cycle.
REQ-030 SHALL test debug write: only dbg_req=1, dbg_write=1, addr 12'h010, data 4'hC -> ram_we=1, dbg_gnt=1, no dbg_rvalid; CPU read of 010 then returns C.
REQ-031 SHALL test reset mid-read: LCD read granted, reset_n low next edge -> lcd_rvalid stays 0, all outputs at reset values.
REQ-032 SHALL test build without RAM_ARBITER_DEBUG_EN: dbg_req=1 held 20 cycles, bus idle -> dbg_gnt=0, ram_we=0 throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port synchronous RAM shared by a CPU, an LCD refresh
// engine and an optional debug port.
// Priority: forced LCD slot > CPU > LCD > debug. The LCD is guaranteed a slot
// after STARVE_LIMIT consecutive denied cycles, and the CPU is stalled for
// that one cycle. Read data returns one cycle after the grant to whichever
// requester issued the read.
// Optional feature: define RAM_ARBITER_DEBUG_EN to arbitrate the debug port.
// Without it the debug ports remain, dbg_req is ignored and the debug outputs
// are tied to zero.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [3:0]  cpu_wdata,
  output logic        cpu_stall,
  output logic [3:0]  cpu_rdata,
  input  logic        lcd_req,
  input  logic [11:0] lcd_addr,
  output logic        lcd_gnt,
  output logic        lcd_rvalid,
  output logic [3:0]  lcd_rdata,
  input  logic        dbg_req,
  input  logic        dbg_write,
  input  logic [11:0] dbg_addr,
  input  logic [3:0]  dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [3:0]  dbg_rdata,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_wdata,
  input  logic [3:0]  ram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LCD, OWN_DBG} owner_e;

  owner_e     grant;
  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] cpu_rdata_q, lcd_rdata_q;
  logic       forced;
  logic       wr_grant;
  logic       dbg_req_en;

`ifdef RAM_ARBITER_DEBUG_EN
  assign dbg_req_en = dbg_req;
`else
  logic unused_dbg_req;
  assign dbg_req_en     = 1'b0;
  assign unused_dbg_req = dbg_req;
`endif

  // Winner selection; nothing is granted while reset is held.
  always_comb begin
    grant  = OWN_NONE;
    forced = 1'b0;
    if (reset_n) begin
      forced = lcd_req && (starve_q == LIMIT);
      if (forced)          grant = OWN_LCD;
      else if (cpu_req)    grant = OWN_CPU;
      else if (lcd_req)    grant = OWN_LCD;
      else if (dbg_req_en) grant = OWN_DBG;
    end
  end

  // RAM bus mux from the winner; an idle cycle drives all zeros.
  always_comb begin
    ram_addr  = 12'h000;
    wr_grant  = 1'b0;
    ram_wdata = 4'h0;
    case (grant)
      OWN_CPU: begin
        ram_addr  = cpu_addr;
        wr_grant  = cpu_write;
        ram_wdata = cpu_wdata;
      end
      OWN_LCD: ram_addr = lcd_addr;
      OWN_DBG: begin
        ram_addr  = dbg_addr;
        wr_grant  = dbg_write;
        ram_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign ram_we    = wr_grant;
  assign cpu_stall = forced;
  assign lcd_gnt   = (grant == OWN_LCD);

  // Next read owner and LCD starvation counter.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant != OWN_NONE && !wr_grant) owner_d = grant;
    starve_d = starve_q;
    if (!lcd_req || lcd_gnt)   starve_d = 4'd0;
    else if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
  end

  // Read data goes straight through in the return cycle, otherwise holds.
  assign lcd_rvalid = (owner_q == OWN_LCD);
  assign cpu_rdata  = (owner_q == OWN_CPU) ? ram_rdata : cpu_rdata_q;
  assign lcd_rdata  = lcd_rvalid ? ram_rdata : lcd_rdata_q;

  // Owner, counter and held read data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_NONE;
      starve_q    <= 4'd0;
      cpu_rdata_q <= 4'h0;
      lcd_rdata_q <= 4'h0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata;
      lcd_rdata_q <= lcd_rdata;
    end
  end

`ifdef RAM_ARBITER_DEBUG_EN
  logic [3:0] dbg_rdata_q;

  assign dbg_gnt    = (grant == OWN_DBG);
  assign dbg_rvalid = (owner_q == OWN_DBG);
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : dbg_rdata_q;

  // Held debug read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dbg_rdata_q <= 4'h0;
    else          dbg_rdata_q <= dbg_rdata;
  end
`else
  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = 4'h0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural model plus directed scenarios and
// randomized traffic; a synchronous RAM model sits behind the DUT.
module tb_ram_arbiter;

  localparam int LIMIT = 8;
`ifdef RAM_ARBITER_DEBUG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_write;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_wdata;
  logic        cpu_stall;
  logic [3:0]  cpu_rdata;
  logic        lcd_req;
  logic [11:0] lcd_addr;
  logic        lcd_gnt, lcd_rvalid;
  logic [3:0]  lcd_rdata;
  logic        dbg_req, dbg_write;
  logic [11:0] dbg_addr;
  logic [3:0]  dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [3:0]  dbg_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata = 4'h0;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_gnt(lcd_gnt),
    .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] init_val(int i);
    return 4'(i * 5 + 3);
  endfunction

  // Synchronous RAM: preloaded on the first edge, read data one cycle later.
  logic [3:0] ram [4096];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who wins, what goes to RAM, what comes back next cycle.
  logic [3:0]  mem_m [4096];
  bit          m_init = 1'b0;
  int          m_starve, m_pend, who;
  logic [11:0] m_paddr;
  logic [3:0]  m_cpu_rd, m_lcd_rd, m_dbg_rd;
  logic [11:0] e_addr;
  logic [3:0]  e_wd;
  bit          e_we, e_stall, e_lg, e_dg, e_lv, e_dv, forced;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 4096; i++) mem_m[i] = init_val(i);
      m_init = 1'b1;
    end
    e_addr = '0; e_wd = '0; e_we = 0; e_stall = 0; e_lg = 0; e_dg = 0;
    e_lv = 0; e_dv = 0;
    if (!reset_n) begin
      m_starve = 0; m_pend = 0; m_paddr = '0;
      m_cpu_rd = '0; m_lcd_rd = '0; m_dbg_rd = '0;
    end else begin
      // returning read from last cycle's grant (1=cpu 2=lcd 3=dbg)
      e_lv = (m_pend == 2);
      e_dv = (m_pend == 3);
      if (m_pend == 1) m_cpu_rd = mem_m[m_paddr];
      if (m_pend == 2) m_lcd_rd = mem_m[m_paddr];
      if (m_pend == 3) m_dbg_rd = mem_m[m_paddr];
      forced = lcd_req && (m_starve == LIMIT);
      if (forced)                 who = 2;
      else if (cpu_req)           who = 1;
      else if (lcd_req)           who = 2;
      else if (DBG_EN && dbg_req) who = 3;
      else                        who = 0;
      e_stall = forced;
      e_lg = (who == 2);
      e_dg = (who == 3);
      if (who == 1) begin e_addr = cpu_addr; e_we = cpu_write; e_wd = cpu_wdata; end
      if (who == 2) e_addr = lcd_addr;
      if (who == 3) begin e_addr = dbg_addr; e_we = dbg_write; e_wd = dbg_wdata; end
      if (e_we) mem_m[e_addr] = e_wd;
      m_pend  = (who != 0 && !e_we) ? who : 0;
      m_paddr = e_addr;
      if (!lcd_req || e_lg)    m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
    end
    chk("ram_addr",   32'(ram_addr),   32'(e_addr));
    chk("ram_we",     32'(ram_we),     32'(e_we));
    chk("ram_wdata",  32'(ram_wdata),  32'(e_wd));
    chk("cpu_stall",  32'(cpu_stall),  32'(e_stall));
    chk("lcd_gnt",    32'(lcd_gnt),    32'(e_lg));
    chk("dbg_gnt",    32'(dbg_gnt),    32'(e_dg));
    chk("lcd_rvalid", 32'(lcd_rvalid), 32'(e_lv));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_dv));
    chk("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rd));
    chk("lcd_rdata",  32'(lcd_rdata),  32'(m_lcd_rd));
    chk("dbg_rdata",  32'(dbg_rdata),  32'(m_dbg_rd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    lcd_req = 0; lcd_addr = '0;
    dbg_req = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    // everything requesting while reset is held
    reset_n = 0;
    cpu_req = 1; cpu_write = 1; cpu_addr = 12'h123; cpu_wdata = 4'hF;
    lcd_req = 1; lcd_addr = 12'h001;
    dbg_req = 1; dbg_write = 1; dbg_addr = 12'h002; dbg_wdata = 4'h3;
    @(negedge clk);
    chk("rst_we",    32'(ram_we),     0);
    chk("rst_stall", 32'(cpu_stall),  0);
    chk("rst_lgnt",  32'(lcd_gnt),    0);
    chk("rst_dgnt",  32'(dbg_gnt),    0);
    chk("rst_lrv",   32'(lcd_rvalid), 0);
    chk("rst_crd",   32'(cpu_rdata),  0);
    step();

    // first cycle after release: CPU write 0A3=5
    reset_n = 1; idle();
    cpu_req = 1; cpu_write = 1; cpu_addr = 12'h0A3; cpu_wdata = 4'h5;
    @(negedge clk);
    chk("first_we",   32'(ram_we),   1);
    chk("first_addr", 32'(ram_addr), 'h0A3);
    step();
    cpu_write = 0;
    @(negedge clk);
    chk("cpurd_addr",  32'(ram_addr),  'h0A3);
    chk("cpurd_stall", 32'(cpu_stall), 0);
    chk("cpurd_we",    32'(ram_we),    0);
    step();
    cpu_write = 1; cpu_addr = 12'hE00; cpu_wdata = 4'h9;
    @(negedge clk);
    chk("cpurd_data", 32'(cpu_rdata), 'h5);
    step();

    // LCD read on an otherwise idle bus
    idle(); lcd_req = 1; lcd_addr = 12'hE00;
    @(negedge clk);
    chk("lcd_gnt_idle",  32'(lcd_gnt),  1);
    chk("lcd_addr_idle", 32'(ram_addr), 'hE00);
    step();
    idle();
    @(negedge clk);
    chk("lcd_rvalid", 32'(lcd_rvalid), 1);
    chk("lcd_rdata",  32'(lcd_rdata),  'h9);
    step();
    @(negedge clk);
    chk("lcd_rvalid_off", 32'(lcd_rvalid), 0);
    chk("lcd_rdata_hold", 32'(lcd_rdata),  'h9);
    step();

    // starvation: CPU and LCD both held; LCD forced in every 9th cycle
    cpu_req = 1; cpu_write = 0; cpu_addr = 12'h0A3;
    lcd_req = 1; lcd_addr = 12'hE00;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("starve_stall", 32'(cpu_stall), (k % 9 == 8) ? 1 : 0);
      chk("starve_lgnt",  32'(lcd_gnt),   (k % 9 == 8) ? 1 : 0);
      chk("starve_addr",  32'(ram_addr),  (k % 9 == 8) ? 'hE00 : 'h0A3);
      step();
    end
    idle();

`ifdef RAM_ARBITER_DEBUG_EN
    // debug write 010=C, then CPU reads it back
    dbg_req = 1; dbg_write = 1; dbg_addr = 12'h010; dbg_wdata = 4'hC;
    @(negedge clk);
    chk("dbgwr_we",  32'(ram_we),  1);
    chk("dbgwr_gnt", 32'(dbg_gnt), 1);
    step();
    idle(); cpu_req = 1; cpu_addr = 12'h010;
    @(negedge clk);
    chk("dbgwr_rvalid", 32'(dbg_rvalid), 0);
    step();
    idle();
    @(negedge clk);
    chk("dbgwr_readback", 32'(cpu_rdata), 'hC);
    step();
`else
    // debug port ignored in this build
    dbg_req = 1; dbg_write = 1; dbg_addr = 12'h010; dbg_wdata = 4'hC;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("nodbg_gnt", 32'(dbg_gnt),    0);
      chk("nodbg_we",  32'(ram_we),     0);
      chk("nodbg_rv",  32'(dbg_rvalid), 0);
      step();
    end
`endif

    // reset lands while an LCD read is in flight
    idle(); lcd_req = 1; lcd_addr = 12'h0A3;
    @(negedge clk);
    chk("midrst_gnt", 32'(lcd_gnt), 1);
    step();
    reset_n = 0; idle();
    @(negedge clk);
    chk("midrst_rv",   32'(lcd_rvalid), 0);
    chk("midrst_lrd",  32'(lcd_rdata),  0);
    chk("midrst_crd",  32'(cpu_rdata),  0);
    chk("midrst_addr", 32'(ram_addr),   0);
    step();
    step();
    reset_n = 1;
    @(negedge clk);
    chk("postrst_rv", 32'(lcd_rvalid), 0);
    step();

    // randomized traffic; the model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      cpu_req   = ($urandom_range(0, 9) < ((n < 1500) ? 9 : 5));
      cpu_write = ($urandom_range(0, 3) == 0);
      cpu_addr  = 12'($urandom_range(0, 31));
      cpu_wdata = 4'($urandom);
      lcd_req   = ($urandom_range(0, 3) != 0);
      lcd_addr  = 12'($urandom_range(0, 31));
      dbg_req   = $urandom_range(0, 1) == 1;
      dbg_write = $urandom_range(0, 1) == 1;
      dbg_addr  = 12'($urandom_range(0, 31));
      dbg_wdata = 4'($urandom);
      step();
    end

    reset_n = 1; idle();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
